// File: rtl/sram_ctrl_pkg.sv
// Shared constants, FSM state encoding and the pin-set helper for the SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_BE_W   = 4;
  localparam int WAIT_CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_ACK      = 3'd5
  } state_e;

  typedef struct packed {
    logic                   ce_n;
    logic                   oe_n;
    logic                   we_n;
    logic [SRAM_BE_W-1:0]   be_n;
    logic [SRAM_ADDR_W-1:0] addr;
    logic                   drive;
  } pin_t;

  localparam pin_t PINS_OFF = '{
    ce_n:  1'b1,
    oe_n:  1'b1,
    we_n:  1'b1,
    be_n:  4'b1111,
    addr:  20'd0,
    drive: 1'b0
  };

  // Pin levels one chip should present while the FSM sits in state st.
  // A chip that is not addressed (hit=0) is always fully inactive.
  function automatic pin_t pins_for(input state_e                 st,
                                    input logic                   hit,
                                    input logic [SRAM_ADDR_W-1:0] addr,
                                    input logic [SRAM_BE_W-1:0]   sel);
    pin_t p;
    p = PINS_OFF;
    if (hit) begin
      case (st)
        S_RD: begin
          p.ce_n = 1'b0;
          p.oe_n = 1'b0;
          p.be_n = 4'b0000;
          p.addr = addr;
        end
        S_WR_SETUP, S_WR_HOLD: begin
          p.ce_n  = 1'b0;
          p.be_n  = ~sel;
          p.addr  = addr;
          p.drive = 1'b1;
        end
        S_WR_PULSE: begin
          p.ce_n  = 1'b0;
          p.we_n  = (sel == 4'b0000);
          p.be_n  = ~sel;
          p.addr  = addr;
          p.drive = 1'b1;
        end
        default: p = PINS_OFF;
      endcase
    end else begin
      p = PINS_OFF;
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Multi-cycle controller for the base/ext 32-bit SRAMs: one request at a time,
// every pin driven from a register so we_n is glitch-free.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [22:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n
);

  localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = {WAIT_CNT_W{1'b0}};
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_CNT_W-1:0] RD_LOAD  = WAIT_CNT_W'(WAIT_RD);
  localparam logic [WAIT_CNT_W-1:0] WR_LOAD  = WAIT_CNT_W'(WAIT_WR - 1);

  state_e                 state_r;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r;
  logic                   chip_r;
  logic [SRAM_ADDR_W-1:0] addr_r;
  logic [SRAM_BE_W-1:0]   sel_r;
  logic [SRAM_DATA_W-1:0] wdata_r;
  logic [SRAM_DATA_W-1:0] rdata_r;
  logic                   ack_r;
  logic                   busy_r;
  pin_t                   base_pins_r;
  pin_t                   ext_pins_r;
  logic                   unused_addr_s;

  assign unused_addr_s = ^addr_i[1:0];

  // FSM, wait counter, request latch and all pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      wait_cnt_r  <= CNT_ZERO;
      chip_r      <= 1'b0;
      addr_r      <= 20'd0;
      sel_r       <= 4'b0000;
      wdata_r     <= 32'd0;
      rdata_r     <= 32'd0;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      base_pins_r <= PINS_OFF;
      ext_pins_r  <= PINS_OFF;
    end else begin
      case (state_r)
        S_IDLE: begin
          ack_r <= 1'b0;
          if (req_i) begin
            chip_r  <= addr_i[22];
            addr_r  <= addr_i[21:2];
            sel_r   <= sel_i;
            wdata_r <= wdata_i;
            busy_r  <= 1'b1;
            if (we_i) begin
              state_r     <= S_WR_SETUP;
              wait_cnt_r  <= CNT_ZERO;
              base_pins_r <= pins_for(S_WR_SETUP, ~addr_i[22], addr_i[21:2], sel_i);
              ext_pins_r  <= pins_for(S_WR_SETUP, addr_i[22], addr_i[21:2], sel_i);
            end else begin
              state_r     <= S_RD;
              wait_cnt_r  <= RD_LOAD;
              base_pins_r <= pins_for(S_RD, ~addr_i[22], addr_i[21:2], sel_i);
              ext_pins_r  <= pins_for(S_RD, addr_i[22], addr_i[21:2], sel_i);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_RD: begin
          // data is sampled on the last edge of the read window
          if (wait_cnt_r == CNT_ZERO) begin
            rdata_r     <= chip_r ? ext_ram_data : base_ram_data;
            ack_r       <= 1'b1;
            state_r     <= S_ACK;
            base_pins_r <= PINS_OFF;
            ext_pins_r  <= PINS_OFF;
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
          end
        end
        S_WR_SETUP: begin
          state_r     <= S_WR_PULSE;
          wait_cnt_r  <= WR_LOAD;
          base_pins_r <= pins_for(S_WR_PULSE, ~chip_r, addr_r, sel_r);
          ext_pins_r  <= pins_for(S_WR_PULSE, chip_r, addr_r, sel_r);
        end
        S_WR_PULSE: begin
          if (wait_cnt_r == CNT_ZERO) begin
            state_r     <= S_WR_HOLD;
            wait_cnt_r  <= CNT_ZERO;
            base_pins_r <= pins_for(S_WR_HOLD, ~chip_r, addr_r, sel_r);
            ext_pins_r  <= pins_for(S_WR_HOLD, chip_r, addr_r, sel_r);
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
          end
        end
        S_WR_HOLD: begin
          ack_r       <= 1'b1;
          state_r     <= S_ACK;
          base_pins_r <= PINS_OFF;
          ext_pins_r  <= PINS_OFF;
        end
        S_ACK: begin
          // req_i is deliberately not looked at here; one idle cycle follows every ack
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          wait_cnt_r  <= CNT_ZERO;
          ack_r       <= 1'b0;
          busy_r      <= 1'b0;
          base_pins_r <= PINS_OFF;
          ext_pins_r  <= PINS_OFF;
        end
      endcase
    end
  end

  assign rdata_o = rdata_r;
  assign ack_o   = ack_r;
  assign busy_o  = busy_r;

  assign base_ram_data = base_pins_r.drive ? wdata_r : 32'bz;
  assign base_ram_addr = base_pins_r.addr;
  assign base_ram_be_n = base_pins_r.be_n;
  assign base_ram_ce_n = base_pins_r.ce_n;
  assign base_ram_oe_n = base_pins_r.oe_n;
  assign base_ram_we_n = base_pins_r.we_n;

  assign ext_ram_data  = ext_pins_r.drive ? wdata_r : 32'bz;
  assign ext_ram_addr  = ext_pins_r.addr;
  assign ext_ram_be_n  = ext_pins_r.be_n;
  assign ext_ram_ce_n  = ext_pins_r.ce_n;
  assign ext_ram_oe_n  = ext_pins_r.oe_n;
  assign ext_ram_we_n  = ext_pins_r.we_n;

endmodule
